// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath widths, the zero register index
// and the register-index type used by the decode and writeback stages.
package pipeline_pkg;

    localparam int PL_DATA_W = 32;
    localparam int PL_ADDR_W = 5;
    localparam int REG_ZERO  = 0;

    typedef logic [PL_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result select: load data or ALU output.
// Also instantiated by the forwarding unit.
module wb_result_mux #(
    parameter int DATA_W = 32
) (
    input  logic              mem_to_reg_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] alu_out_i,
    output logic [DATA_W-1:0] result_o
);

    assign result_o = mem_to_reg_i ? read_data_i : alu_out_i;

endmodule

// File: rtl/wb_register_file.sv
// Writeback-stage register file: 32 flop entries, r0 hardwired to zero.
// Define WB_REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module wb_register_file
    import pipeline_pkg::*;
#(
    parameter int DATA_W = PL_DATA_W,
    parameter int ADDR_W = PL_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWW,
    input  logic              MemToRegW,
    input  logic [DATA_W-1:0] ReadDataW,
    input  logic [DATA_W-1:0] ALUOutW,
    input  logic [ADDR_W-1:0] WriteRegW,
    input  logic [ADDR_W-1:0] A1D,
    input  logic [ADDR_W-1:0] A2D,
    output logic [DATA_W-1:0] RD1D,
    output logic [DATA_W-1:0] RD2D,
    output logic [DATA_W-1:0] ResultW
);

    localparam int                NREGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_en;

    wb_result_mux #(
        .DATA_W(DATA_W)
    ) u_result_mux (
        .mem_to_reg_i(MemToRegW),
        .read_data_i (ReadDataW),
        .alu_out_i   (ALUOutW),
        .result_o    (ResultW)
    );

    assign wr_en = RegWW && (WriteRegW != ZERO_IDX);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[WriteRegW] = ResultW;
        end
    end

    // Flops rather than a memory macro so the whole bank clears asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        RD1D = regs_q[A1D];
        RD2D = regs_q[A2D];
`ifdef WB_REGFILE_BYPASS_EN
        if (wr_en && (WriteRegW == A1D)) begin
            RD1D = ResultW;
        end
        if (wr_en && (WriteRegW == A2D)) begin
            RD2D = ResultW;
        end
`endif
        // Zero override last so a bypass can never leak into r0.
        if (A1D == ZERO_IDX) begin
            RD1D = '0;
        end
        if (A2D == ZERO_IDX) begin
            RD2D = '0;
        end
    end

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file; expected read and result
// values are queued from a reference model and compared against the DUT.
module tb_wb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWW;
    logic        MemToRegW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic [4:0]  WriteRegW;
    logic [4:0]  A1D;
    logic [4:0]  A2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ResultW;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m[32];
    int          checks = 0;
    int          errors = 0;

    wb_register_file dut (
        .clk      (clk),
        .reset    (reset),
        .RegWW    (RegWW),
        .MemToRegW(MemToRegW),
        .ReadDataW(ReadDataW),
        .ALUOutW  (ALUOutW),
        .WriteRegW(WriteRegW),
        .A1D      (A1D),
        .A2D      (A2D),
        .RD1D     (RD1D),
        .RD2D     (RD2D),
        .ResultW  (ResultW)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h want %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_res();
        return MemToRegW ? ReadDataW : ALUOutW;
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
        if (RegWW && WriteRegW != 5'd0 && WriteRegW == a) return model_res();
`endif
        return m[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
    endtask

    task automatic drive(input logic we, input logic mtr,
                         input logic [31:0] rdata, input logic [31:0] alu,
                         input logic [4:0] wr, input logic [4:0] a1,
                         input logic [4:0] a2);
        RegWW     = we;
        MemToRegW = mtr;
        ReadDataW = rdata;
        ALUOutW   = alu;
        WriteRegW = wr;
        A1D       = a1;
        A2D       = a2;
    endtask

    task automatic observe(input string tag);
        exp_t e;
        sbq.push_back('{{tag, "_rd1"}, model_rd(A1D)});
        sbq.push_back('{{tag, "_rd2"}, model_rd(A2D)});
        sbq.push_back('{{tag, "_res"}, model_res()});
        #1;
        if (sbq.size() < 3) begin
            check({tag, "_sbq"}, 32'(sbq.size()), 32'd3);
        end else begin
            e = sbq.pop_front(); check(e.tag, RD1D, e.exp);
            e = sbq.pop_front(); check(e.tag, RD2D, e.exp);
            e = sbq.pop_front(); check(e.tag, ResultW, e.exp);
        end
    endtask

    task automatic commit();
        if (!reset && RegWW && WriteRegW != 5'd0) m[WriteRegW] = model_res();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_model();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            A1D = 5'(i);
            A2D = 5'(31 - i);
            observe("rst_init");
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Preload every register, then pulse reset between edges.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, i[0], 32'h0101_0101 * i, 32'h1000_0000 + i,
                  5'(i), 5'd0, 5'd0);
            commit();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd17, 5'd30);
        observe("preload");
        #2;
        reset = 1'b1;
        clear_model();
        for (int i = 0; i < 32; i++) begin
            A1D = 5'(i);
            A2D = 5'(31 - i);
            observe("rst_mid");
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        drive(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd5, 5'd0, 5'd0);
        commit();
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 5'd6, 5'd5, 5'd0);
        observe("alu_wr5");
        commit();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6);
        observe("mem_wr6");
        check("reg5_const", RD1D, 32'h1234_5678);
        check("reg6_const", RD2D, 32'hDEAD_BEEF);

        drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd5);
        observe("r0_same");
        commit();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        observe("r0_after");

        drive(1'b1, 1'b0, 32'h0, 32'h0000_0011, 5'd7, 5'd0, 5'd0);
        commit();
        drive(1'b0, 1'b0, 32'h0, 32'hAAAA_5555, 5'd7, 5'd7, 5'd0);
        observe("nowe_same");
        commit();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
        observe("nowe_after");
        check("reg7_const", RD1D, 32'h0000_0011);

        drive(1'b1, 1'b0, 32'h0, 32'h0000_0001, 5'd9, 5'd0, 5'd0);
        commit();
        drive(1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 5'd9, 5'd9, 5'd9);
        observe("byp_same");
`ifdef WB_REGFILE_BYPASS_EN
        check("byp_const", RD2D, 32'hCAFE_F00D);
`else
        check("nobyp_const", RD2D, 32'h0000_0001);
`endif
        commit();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
        observe("byp_next");

        // Reset raised on the same edge as a pending write to r3.
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0033, 5'd3, 5'd3, 5'd3);
        @(posedge clk);
        reset = 1'b1;
        clear_model();
        #1;
        RegWW = 1'b0;
        observe("rst_edge");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        observe("rst_edge_after");
        check("reg3_const", RD1D, 32'h0);
        drive(1'b1, 1'b1, 32'h3333_3333, 32'h0, 5'd3, 5'd0, 5'd0);
        commit();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
        observe("post_rst_wr");

        for (int k = 0; k < 200; k++) begin
            drive(1'($urandom), 1'($urandom), $urandom, $urandom,
                  5'($urandom), 5'($urandom), 5'($urandom));
            if (k % 7 == 0) A1D = WriteRegW;
            observe("rand");
            commit();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
